// File: rtl/filter_stream_if.sv
// Weight-buffer read port and PE weight-stream handshake used by filter_stream_ctrl.
// master = the controller; slave = the buffer/FIFO side.
interface filter_stream_if #(
  parameter int ADDR_W = 12,
  parameter int F      = 4,
  parameter int DATA_W = 8
);
  logic                mem_rd_en;
  logic [ADDR_W-1:0]   mem_rd_addr;
  logic [F*DATA_W-1:0] mem_rd_data;
  logic                wt_valid;
  logic [F*DATA_W-1:0] wt_data;
  logic                wt_last;
  logic                wt_ready;

  modport master (
    output mem_rd_en, mem_rd_addr, wt_valid, wt_data, wt_last,
    input  mem_rd_data, wt_ready
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr, wt_valid, wt_data, wt_last,
    output mem_rd_data, wt_ready
  );
endinterface

// File: rtl/filter_stream_ctrl.sv
// Fetches the compressed weight segment for a (layer, k) request and streams it to the
// PE weight FIFO through a 2-entry skid buffer; reports filter/input completion levels.
//
// state | meaning
// IDLE  | wait for a request whose tag differs from the last delivered tag
// FETCH | issue buffer reads while read credit is available
// DRAIN | all reads issued; wait for the final beat to be accepted
// DONE  | one cycle; record the delivered tag
module filter_stream_ctrl #(
  parameter int NUM_LAYER = 4,
  parameter int MAX_K     = 64,
  parameter int ADDR_W    = 12,
  parameter int F         = 4,
  parameter int DATA_W    = 8,
  parameter int LEN_W     = 8,
  localparam int KW       = $clog2(MAX_K),
  localparam int LYW      = $clog2(NUM_LAYER) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_filter_valid,
  input  logic [KW-1:0]                 req_filter_k,
  input  logic [LYW-1:0]                req_conv_layer,
  input  logic                          req_input_valid,
  input  logic [NUM_LAYER*ADDR_W-1:0]   cfg_base_addr,
  input  logic [NUM_LAYER*LEN_W-1:0]    cfg_beats_per_k,
  filter_stream_if.master               bus,
  output logic                          input_stream_start,
  input  logic                          input_stream_done,
  output logic                          stream_filter_finish,
  output logic                          stream_input_finish
);

  localparam int TW     = LYW + KW;
  localparam int KOFF_W = KW + LEN_W;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t              state, state_nx;
  logic [TW-1:0]       req_tag, cur_tag, done_tag;
  logic                done_tag_valid;
  logic                new_req;
  logic [ADDR_W-1:0]   base_sel, start_addr, rd_addr;
  logic [LEN_W-1:0]    beats_sel, rd_left, tx_left;
  logic [KOFF_W-1:0]   k_off;
  logic                issue, pop, rd_pend;
  logic [1:0]          in_flight, skid_cnt;
  logic [F*DATA_W-1:0] skid [2];
  logic                wr_ptr, rd_ptr;
  logic                input_started;

  assign req_tag = {req_conv_layer, req_filter_k};
  assign new_req = req_filter_valid && (!done_tag_valid || (req_tag != done_tag));

  // Out-of-range layer numbers select base 0 / zero beats.
  always_comb begin
    base_sel  = '0;
    beats_sel = '0;
    for (int i = 0; i < NUM_LAYER; i++) begin
      if (req_conv_layer == LYW'(i)) begin
        base_sel  = cfg_base_addr[i*ADDR_W +: ADDR_W];
        beats_sel = cfg_beats_per_k[i*LEN_W +: LEN_W];
      end
    end
    k_off      = KOFF_W'(req_filter_k) * KOFF_W'(beats_sel);
    start_addr = base_sel + ADDR_W'(k_off);
  end

  assign bus.wt_valid = (skid_cnt != 2'd0);
  assign bus.wt_data  = skid[rd_ptr];
  assign bus.wt_last  = bus.wt_valid && (tx_left == LEN_W'(1));
  assign pop          = bus.wt_valid && bus.wt_ready;

  // Reads in flight plus beats held after this cycle's pop must leave room in the skid.
  assign in_flight = skid_cnt + {1'b0, rd_pend} - {1'b0, pop};

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    case (state)
      IDLE: begin
        if (new_req) begin
          state_nx = (beats_sel == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (in_flight < 2'd2) begin
          issue = 1'b1;
          if (rd_left == LEN_W'(1)) begin
            state_nx = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && (tx_left == LEN_W'(1))) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.mem_rd_en   = issue;
  assign bus.mem_rd_addr = issue ? rd_addr : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= IDLE;
      cur_tag              <= '0;
      done_tag             <= '0;
      done_tag_valid       <= 1'b0;
      rd_addr              <= '0;
      rd_left              <= '0;
      tx_left              <= '0;
      rd_pend              <= 1'b0;
      skid[0]              <= '0;
      skid[1]              <= '0;
      wr_ptr               <= 1'b0;
      rd_ptr               <= 1'b0;
      skid_cnt             <= 2'd0;
      stream_filter_finish <= 1'b0;
      input_started        <= 1'b0;
      input_stream_start   <= 1'b0;
      stream_input_finish  <= 1'b0;
    end else begin
      state <= state_nx;

      if ((state == IDLE) && new_req) begin
        cur_tag <= req_tag;
        rd_addr <= start_addr;
        rd_left <= beats_sel;
        tx_left <= beats_sel;
      end else begin
        if (issue) begin
          rd_addr <= rd_addr + ADDR_W'(1);
          rd_left <= rd_left - LEN_W'(1);
        end
        if (pop) begin
          tx_left <= tx_left - LEN_W'(1);
        end
      end

      // Buffer data is valid the cycle after the strobe.
      rd_pend <= issue;
      if (rd_pend) begin
        skid[wr_ptr] <= bus.mem_rd_data;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      skid_cnt <= skid_cnt + {1'b0, rd_pend} - {1'b0, pop};

      if (state == DONE) begin
        done_tag       <= cur_tag;
        done_tag_valid <= 1'b1;
      end

      stream_filter_finish <= req_filter_valid && done_tag_valid && (req_tag == done_tag);

      input_stream_start <= req_input_valid && !input_started;
      if (req_input_valid) begin
        input_started <= 1'b1;
      end
      if (input_stream_done) begin
        stream_input_finish <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_filter_stream_ctrl.sv
// Directed bench for filter_stream_ctrl: a segment-level model (expected read addresses and
// beats in order) checked every cycle, plus hand-computed timing and address literals.
module tb_filter_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_filter_valid;
  logic [5:0]  req_filter_k;
  logic [2:0]  req_conv_layer;
  logic        req_input_valid;
  logic [47:0] cfg_base_addr;
  logic [31:0] cfg_beats_per_k;
  logic        input_stream_start;
  logic        input_stream_done;
  logic        stream_filter_finish;
  logic        stream_input_finish;

  filter_stream_if bus ();

  filter_stream_ctrl dut (
    .clk                  (clk),
    .rst                  (rst),
    .req_filter_valid     (req_filter_valid),
    .req_filter_k         (req_filter_k),
    .req_conv_layer       (req_conv_layer),
    .req_input_valid      (req_input_valid),
    .cfg_base_addr        (cfg_base_addr),
    .cfg_beats_per_k      (cfg_beats_per_k),
    .bus                  (bus),
    .input_stream_start   (input_stream_start),
    .input_stream_done    (input_stream_done),
    .stream_filter_finish (stream_filter_finish),
    .stream_input_finish  (stream_input_finish)
  );

  always #5 clk = ~clk;

  int base_tab [4]  = '{'h010, 'h100, 'h200, 'h300};
  int beats_tab [4] = '{3, 4, 0, 3};

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] exp_addr [$];
  logic [31:0] exp_data [$];
  logic        exp_last [$];
  logic [11:0] seen_addr [$];
  int          xfer_cnt;
  logic        stall_q;
  logic [32:0] held_q;

  function automatic logic [31:0] mem_word(input logic [11:0] a);
    return {~a[7:0], a[11:4], a[7:0] ^ 8'h5A, a[3:0], 4'h9};
  endfunction

  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= mem_word(bus.mem_rd_addr);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic push_seg(input int layer, input int k);
    int b;
    logic [11:0] a;
    b = beats_tab[layer];
    a = 12'(base_tab[layer] + k * b);
    for (int i = 0; i < b; i++) begin
      exp_addr.push_back(a + 12'(i));
      exp_data.push_back(mem_word(a + 12'(i)));
      exp_last.push_back(i == b - 1);
    end
  endtask

  task automatic new_test();
    seen_addr.delete();
    xfer_cnt = 0;
  endtask

  // Per-cycle compare against the segment model.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.mem_rd_en) begin
        seen_addr.push_back(bus.mem_rd_addr);
        if (exp_addr.size() == 0) fail_now("unexpected_read");
        else check("rd_addr", 64'(bus.mem_rd_addr), 64'(exp_addr.pop_front()));
      end
      if (bus.wt_valid) begin
        if (stall_q) check("stall_stable", 64'({bus.wt_last, bus.wt_data}), 64'(held_q));
        if (bus.wt_ready) begin
          xfer_cnt++;
          if (exp_data.size() == 0) fail_now("unexpected_beat");
          else begin
            check("wt_data", 64'(bus.wt_data), 64'(exp_data.pop_front()));
            check("wt_last", 64'(bus.wt_last), 64'(exp_last.pop_front()));
          end
        end
      end else if (bus.wt_last) begin
        fail_now("last_without_valid");
      end
      stall_q = bus.wt_valid && !bus.wt_ready;
      held_q  = {bus.wt_last, bus.wt_data};
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n counts edges since the request was driven; returns first wt_valid and first finish cycle.
  task automatic run_seg(input int max, input bit toggle, output int n_valid, output int n_fin);
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int n = 0;
    n_valid = -1;
    n_fin   = -1;
    while (n < max && n_fin < 0) begin
      bus.wt_ready = toggle ? pat[n % 4] : 1'b1;
      tick();
      n++;
      if (bus.wt_valid && n_valid < 0) n_valid = n;
      if (stream_filter_finish) n_fin = n;
    end
    if (n_fin < 0) fail_now("finish_timeout");
    bus.wt_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv, nf, starts;
    rst               = 1'b0;
    req_filter_valid  = 1'b0;
    req_filter_k      = '0;
    req_conv_layer    = '0;
    req_input_valid   = 1'b0;
    input_stream_done = 1'b0;
    bus.wt_ready      = 1'b1;
    cfg_base_addr     = {12'h300, 12'h200, 12'h100, 12'h010};
    cfg_beats_per_k   = {8'd3, 8'd0, 8'd4, 8'd3};
    stall_q           = 1'b0;
    held_q            = '0;
    xfer_cnt          = 0;

    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("rst_wt_valid", 64'(bus.wt_valid), 64'd0);
    check("rst_mem_rd_en", 64'(bus.mem_rd_en), 64'd0);
    check("rst_filter_finish", 64'(stream_filter_finish), 64'd0);
    check("rst_input_finish", 64'(stream_input_finish), 64'd0);
    check("rst_input_start", 64'(input_stream_start), 64'd0);

    // Layer 0, k=0: reads 0x010..0x012, wt_valid from cycle 3, finish at cycle 8.
    new_test();
    push_seg(0, 0);
    req_conv_layer = 3'd0; req_filter_k = 6'd0; req_filter_valid = 1'b1;
    run_seg(40, 1'b0, nv, nf);
    check("t1_first_valid", 64'(nv), 64'd3);
    check("t1_finish", 64'(nf), 64'd8);
    check("t1_beats", 64'(xfer_cnt), 64'd3);
    check("t1_nreads", 64'(seen_addr.size()), 64'd3);
    if (seen_addr.size() == 3) begin
      check("t1_addr0", 64'(seen_addr[0]), 64'h010);
      check("t1_addr2", 64'(seen_addr[2]), 64'h012);
    end

    // Layer 1, k=5 with stalling FIFO: 0x114..0x117, four beats.
    new_test();
    push_seg(1, 5);
    req_conv_layer = 3'd1; req_filter_k = 6'd5;
    run_seg(60, 1'b1, nv, nf);
    check("t2_first_valid", 64'(nv), 64'd3);
    check("t2_beats", 64'(xfer_cnt), 64'd4);
    check("t2_nreads", 64'(seen_addr.size()), 64'd4);
    if (seen_addr.size() == 4) begin
      check("t2_addr0", 64'(seen_addr[0]), 64'h114);
      check("t2_addr3", 64'(seen_addr[3]), 64'h117);
    end
    check("t2_model_empty", 64'(exp_data.size()), 64'd0);

    // Layer 2 has zero beats: no reads, no beats, finish at cycle 3.
    new_test();
    req_conv_layer = 3'd2; req_filter_k = 6'd1;
    run_seg(20, 1'b0, nv, nf);
    check("t3_finish", 64'(nf), 64'd3);
    check("t3_no_valid", 64'(nv), 64'hFFFF_FFFF_FFFF_FFFF);
    check("t3_nreads", 64'(seen_addr.size()), 64'd0);

    // Layer 3: k=2 requested, switched to k=3 mid-stream; both segments complete in order.
    new_test();
    push_seg(3, 2);
    push_seg(3, 3);
    req_conv_layer = 3'd3; req_filter_k = 6'd2;
    nf = -1;
    for (int n = 1; n <= 60 && nf < 0; n++) begin
      if (n == 3) req_filter_k = 6'd3;
      tick();
      if (stream_filter_finish) begin
        nf = n;
        if (xfer_cnt < 6) fail_now("t4_early_finish");
      end
    end
    if (nf < 0) fail_now("t4_finish_timeout");
    check("t4_beats", 64'(xfer_cnt), 64'd6);
    check("t4_nreads", 64'(seen_addr.size()), 64'd6);
    if (seen_addr.size() == 6) begin
      check("t4_addr0", 64'(seen_addr[0]), 64'h306);
      check("t4_addr3", 64'(seen_addr[3]), 64'h309);
      check("t4_addr5", 64'(seen_addr[5]), 64'h30B);
    end
    // Same tag held: no refetch, finish stays high.
    for (int n = 0; n < 5; n++) begin
      tick();
      check("t4_finish_hold", 64'(stream_filter_finish), 64'd1);
    end
    check("t4_no_refetch", 64'(seen_addr.size()), 64'd6);
    req_filter_valid = 1'b0;
    tick();
    tick();
    check("t4_finish_drop", 64'(stream_filter_finish), 64'd0);

    // Input streamer: valid for 10 cycles, done driven in cycle 7.
    starts = 0;
    for (int n = 0; n < 12; n++) begin
      req_input_valid   = (n < 10);
      input_stream_done = (n == 7);
      tick();
      if (input_stream_start) begin
        starts++;
        check("t5_start_cycle", 64'(n + 1), 64'd1);
      end
      if (n + 1 == 7) check("t5_in_finish_low", 64'(stream_input_finish), 64'd0);
      if (n + 1 >= 8) check("t5_in_finish_high", 64'(stream_input_finish), 64'd1);
    end
    req_input_valid   = 1'b0;
    input_stream_done = 1'b0;
    check("t5_start_count", 64'(starts), 64'd1);

    // Reset mid-fetch with the FIFO stalled.
    new_test();
    push_seg(1, 7);
    bus.wt_ready = 1'b0;
    req_conv_layer = 3'd1; req_filter_k = 6'd7; req_filter_valid = 1'b1;
    repeat (3) tick();
    check("t6_valid_before_rst", 64'(bus.wt_valid), 64'd1);
    rst = 1'b0;
    #1;
    check("t6_rst_valid", 64'(bus.wt_valid), 64'd0);
    check("t6_rst_rd_en", 64'(bus.mem_rd_en), 64'd0);
    check("t6_rst_data", 64'(bus.wt_data), 64'd0);
    check("t6_rst_last", 64'(bus.wt_last), 64'd0);
    check("t6_rst_in_finish", 64'(stream_input_finish), 64'd0);
    exp_addr.delete();
    exp_data.delete();
    exp_last.delete();
    req_filter_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      check("t6_idle_valid", 64'(bus.wt_valid), 64'd0);
      check("t6_idle_finish", 64'(stream_filter_finish), 64'd0);
    end
    // Tag (3,3) was delivered before reset; it must be fetched again.
    new_test();
    push_seg(3, 3);
    req_conv_layer = 3'd3; req_filter_k = 6'd3; req_filter_valid = 1'b1;
    run_seg(40, 1'b0, nv, nf);
    check("t6_refetch_valid", 64'(nv), 64'd3);
    check("t6_refetch_finish", 64'(nf), 64'd8);
    check("t6_refetch_beats", 64'(xfer_cnt), 64'd3);
    if (seen_addr.size() > 0) check("t6_refetch_addr0", 64'(seen_addr[0]), 64'h309);
    else fail_now("t6_no_reads");
    req_filter_valid = 1'b0;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
